// File: rtl/dsp_mac_dump.sv
// dsp_mac_dump: pipelined multiply-accumulate with integrate-and-dump
module dsp_mac_dump #(
    parameter int WIDTH_A  = 16,
    parameter int WIDTH_B  = 16,
    parameter int ACC_W    = 40,
    parameter int SIGNED   = 0,
    parameter int PIPE     = 2,
    parameter int DUMP_LEN = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [WIDTH_A-1:0] A,
    input  logic [WIDTH_B-1:0] B,
    input  logic               clear,
    output logic [ACC_W-1:0]   X,
    output logic               out_valid,
    output logic               overflow
);
    localparam int WP = WIDTH_A + WIDTH_B;
    logic signed [WP-1:0] prod_s;
    logic [WP-1:0]        prod_u;
    logic [ACC_W-1:0]     prod, p, acc, sum;
    logic [ACC_W:0]       sum_c;
    logic [ACC_W-1:0]     pd [PIPE];
    logic [PIPE-1:0]      pv;
    logic [15:0]          cnt;
    logic                 sticky, add, last, ovf_add;
    assign prod_s  = WP'($signed(A)) * WP'($signed(B));
    assign prod_u  = WP'(A) * WP'(B);
    assign prod    = SIGNED != 0 ? ACC_W'(prod_s) : ACC_W'(prod_u);
    assign p       = pd[PIPE-1];
    assign add     = pv[PIPE-1] && !clear;
    assign last    = cnt == 16'(DUMP_LEN - 1);
    assign sum_c   = {1'b0, acc} + {1'b0, p};
    assign sum     = sum_c[ACC_W-1:0];
    assign ovf_add = SIGNED != 0 ? (acc[ACC_W-1] == p[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1])
                                 : sum_c[ACC_W];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pv <= '0;
            for (int i = 0; i < PIPE; i++) pd[i] <= '0;
        end else begin
            pv    <= PIPE'({pv, in_valid}) & (clear ? PIPE'(1) : {PIPE{1'b1}});
            pd[0] <= prod;
            for (int i = 1; i < PIPE; i++) pd[i] <= pd[i-1];
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            X         <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= add && last;
            if (clear) begin
                acc    <= '0;
                cnt    <= '0;
                sticky <= 1'b0;
            end else if (add) begin
                acc    <= last ? '0 : sum;
                cnt    <= last ? '0 : cnt + 16'd1;
                sticky <= last ? 1'b0 : sticky | ovf_add;
                if (last) begin
                    X        <= sum;
                    overflow <= sticky | ovf_add;
                end
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_dump.sv
// tb_dsp_mac_dump: scoreboard bench over three configurations of the MAC
module tb_dsp_mac_dump;
    typedef struct {
        longint x;
        bit     ovf;
        int     cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tv[3], tc[3];
    logic [15:0] ta[3], tbv[3];
    logic [39:0] x0, x1;
    logic [31:0] x2;
    logic ov0, ov1, ov2, of0, of1, of2;

    int checks = 0, failures = 0, cyc = 0;
    int aw[3] = '{40, 40, 32};
    bit sg[3] = '{0, 1, 0};
    int dl[3] = '{4, 2, 2};
    int pp[3] = '{2, 1, 3};
    longint acc_m[3], lastx[3];
    int cnt_m[3];
    bit ovf_m[3], lasto[3];
    exp_t q[3][$];

    dsp_mac_dump #(.ACC_W(40), .SIGNED(0), .PIPE(2), .DUMP_LEN(4)) u0 (
        .clock(clock), .reset(reset), .in_valid(tv[0]), .A(ta[0]), .B(tbv[0]),
        .clear(tc[0]), .X(x0), .out_valid(ov0), .overflow(of0));
    dsp_mac_dump #(.ACC_W(40), .SIGNED(1), .PIPE(1), .DUMP_LEN(2)) u1 (
        .clock(clock), .reset(reset), .in_valid(tv[1]), .A(ta[1]), .B(tbv[1]),
        .clear(tc[1]), .X(x1), .out_valid(ov1), .overflow(of1));
    dsp_mac_dump #(.ACC_W(32), .SIGNED(0), .PIPE(3), .DUMP_LEN(2)) u2 (
        .clock(clock), .reset(reset), .in_valid(tv[2]), .A(ta[2]), .B(tbv[2]),
        .clear(tc[2]), .X(x2), .out_valid(ov2), .overflow(of2));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic mon(int i, logic [63:0] xv, logic ov, logic of);
        bit e = q[i].size() > 0 && q[i][0].cyc == cyc;
        check($sformatf("u%0d.strobe", i), 64'(ov), 64'(e));
        if (e) begin
            lastx[i] = q[i][0].x;
            lasto[i] = q[i][0].ovf;
            void'(q[i].pop_front());
        end
        check($sformatf("u%0d.x", i), xv, 64'(lastx[i]));
        check($sformatf("u%0d.ovf", i), 64'(of), 64'(lasto[i]));
    endtask

    always @(negedge clock) begin
        mon(0, 64'(x0), ov0, of0);
        mon(1, 64'(x1), ov1, of1);
        mon(2, 64'(x2), ov2, of2);
    end

    task automatic model(int i, bit c, bit v, logic [15:0] a, logic [15:0] b);
        longint m = (longint'(1) << aw[i]) - 1;
        longint h = longint'(1) << (aw[i] - 1);
        longint p, pm, sacc, t;
        bit o;
        if (c) begin
            while (q[i].size() > 0 && q[i][$].cyc > cyc) void'(q[i].pop_back());
            acc_m[i] = 0;
            cnt_m[i] = 0;
            ovf_m[i] = 0;
        end
        if (v) begin
            if (sg[i]) p = longint'($signed(a)) * longint'($signed(b));
            else p = longint'(a) * longint'(b);
            pm = p & m;
            if (sg[i]) begin
                sacc = acc_m[i] >= h ? acc_m[i] - m - 1 : acc_m[i];
                t = sacc + p;
                o = t >= h || t < -h;
            end else o = acc_m[i] + pm > m;
            acc_m[i] = (acc_m[i] + pm) & m;
            ovf_m[i] = ovf_m[i] | o;
            cnt_m[i]++;
            if (cnt_m[i] == dl[i]) begin
                q[i].push_back('{x: acc_m[i], ovf: ovf_m[i], cyc: cyc + pp[i] + 1});
                acc_m[i] = 0;
                cnt_m[i] = 0;
                ovf_m[i] = 0;
            end
        end
    endtask

    task automatic drive(int i, bit v, logic [15:0] a, logic [15:0] b, bit c = 1'b0);
        @(posedge clock);
        #1;
        tv[i] = v;
        ta[i] = a;
        tbv[i] = b;
        tc[i] = c;
        model(i, c, v, a, b);
    endtask

    task automatic idle(int i, int n);
        drive(i, 1'b0, 16'd0, 16'd0);
        repeat (n) @(posedge clock);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            acc_m[i] = 0;
            cnt_m[i] = 0;
            ovf_m[i] = 0;
            lastx[i] = 0;
            lasto[i] = 0;
            tv[i] = 1'b0;
            tc[i] = 1'b0;
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, ".x0"}, 64'(x0), 64'd0);
        check({tag, ".x1"}, 64'(x1), 64'd0);
        check({tag, ".x2"}, 64'(x2), 64'd0);
        check({tag, ".ov"}, 64'({ov0, ov1, ov2}), 64'd0);
        check({tag, ".of"}, 64'({of0, of1, of2}), 64'd0);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) begin
            ta[i] = '0;
            tbv[i] = '0;
        end
        repeat (3) @(negedge clock);
        check_zero("rst");
        reset = 1'b0;
        // u0 unsigned, four back-to-back samples then the same with bubbles
        for (int k = 1; k <= 4; k++) drive(0, 1'b1, 16'd200, 16'(3 * k));
        idle(0, 6);
        for (int k = 1; k <= 4; k++) begin
            drive(0, 1'b1, 16'd200, 16'(3 * k));
            drive(0, 1'b0, 16'hDEAD, 16'hBEEF);
        end
        idle(0, 6);
        for (int k = 1; k <= 100; k++) drive(0, 1'b1, 16'd200, 16'(3 * k));
        idle(0, 6);
        // u1 signed: -3*7 + 2*-5 = -31
        drive(1, 1'b1, 16'hFFFD, 16'd7);
        drive(1, 1'b1, 16'd2, 16'hFFFB);
        idle(1, 5);
        // u2 32-bit accumulator wraps, then a clean period
        drive(2, 1'b1, 16'hFFFF, 16'hFFFF);
        drive(2, 1'b1, 16'hFFFF, 16'hFFFF);
        idle(2, 6);
        drive(2, 1'b1, 16'd5, 16'd6);
        drive(2, 1'b1, 16'd7, 16'd8);
        idle(2, 6);
        // u0 clear mid-period, clear together with a sample, clear on the dump cycle
        drive(0, 1'b1, 16'd100, 16'd1);
        drive(0, 1'b1, 16'd100, 16'd2);
        drive(0, 1'b0, 16'd0, 16'd0, 1'b1);
        for (int k = 1; k <= 4; k++) drive(0, 1'b1, 16'd7, 16'(k));
        idle(0, 6);
        drive(0, 1'b1, 16'd300, 16'd300);
        drive(0, 1'b1, 16'd10, 16'd10, 1'b1);
        for (int k = 1; k <= 3; k++) drive(0, 1'b1, 16'd11, 16'(k));
        idle(0, 6);
        for (int k = 1; k <= 4; k++) drive(0, 1'b1, 16'd9, 16'(k));
        drive(0, 1'b0, 16'd0, 16'd0);
        drive(0, 1'b0, 16'd0, 16'd0, 1'b1);
        idle(0, 6);
        // randomised traffic
        for (int n = 0; n < 60; n++)
            drive(1, $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));
        idle(1, 4);
        for (int n = 0; n < 60; n++)
            drive(2, $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));
        idle(2, 6);
        for (int n = 0; n < 120; n++)
            drive(0, $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  $urandom_range(0, 15) == 0);
        idle(0, 6);
        // async reset with products in flight
        drive(0, 1'b1, 16'd1000, 16'd1000);
        drive(0, 1'b1, 16'd1000, 16'd1000);
        drive(0, 1'b1, 16'd1000, 16'd1000);
        drive(0, 1'b1, 16'd1000, 16'd1000);
        drive(1, 1'b1, 16'd50, 16'd50);
        @(posedge clock);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_zero("async_rst");
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        for (int k = 1; k <= 4; k++) drive(0, 1'b1, 16'd200, 16'(3 * k));
        idle(0, 8);
        for (int i = 0; i < 3; i++) check($sformatf("u%0d.drain", i), 64'(q[i].size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
